// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, dp bit, index width.
// Segment bit order is {dp, g, f, e, d, c, b, a}.
package seg7_pkg;

  localparam int SEG_DP = 7;

  localparam logic [7:0] GLYPH_0 = 8'h3F;
  localparam logic [7:0] GLYPH_1 = 8'h06;
  localparam logic [7:0] GLYPH_2 = 8'h5B;
  localparam logic [7:0] GLYPH_3 = 8'h4F;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'h6D;
  localparam logic [7:0] GLYPH_6 = 8'h7D;
  localparam logic [7:0] GLYPH_7 = 8'h07;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h67;
  localparam logic [7:0] GLYPH_A = 8'h77;
  localparam logic [7:0] GLYPH_B = 8'h7C;
  localparam logic [7:0] GLYPH_C = 8'h39;
  localparam logic [7:0] GLYPH_D = 8'h5E;
  localparam logic [7:0] GLYPH_E = 8'h79;
  localparam logic [7:0] GLYPH_F = 8'h71;

  // A single-digit display still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to a..g segment pattern (active-high, no dp).
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (nib_i)
      4'h0:    seg_o = GLYPH_0[6:0];
      4'h1:    seg_o = GLYPH_1[6:0];
      4'h2:    seg_o = GLYPH_2[6:0];
      4'h3:    seg_o = GLYPH_3[6:0];
      4'h4:    seg_o = GLYPH_4[6:0];
      4'h5:    seg_o = GLYPH_5[6:0];
      4'h6:    seg_o = GLYPH_6[6:0];
      4'h7:    seg_o = GLYPH_7[6:0];
      4'h8:    seg_o = GLYPH_8[6:0];
      4'h9:    seg_o = GLYPH_9[6:0];
      4'hA:    seg_o = GLYPH_A[6:0];
      4'hB:    seg_o = GLYPH_B[6:0];
      4'hC:    seg_o = GLYPH_C[6:0];
      4'hD:    seg_o = GLYPH_D[6:0];
      4'hE:    seg_o = GLYPH_E[6:0];
      default: seg_o = GLYPH_F[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed hex seven-segment scanner with frame-aligned (tear-free) updates and registered outputs.
// Optional leading-zero blanking is compiled in with `define SEG7_LZB_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int DEAD     = 1,
  parameter bit SEG_INV  = 1'b0,
  parameter bit DIG_INV  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = idx_w(DIGITS);
  localparam logic [CW-1:0]     CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = {8{SEG_INV}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_INV}};

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] stg_val_q, stg_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic                pending_q, pending_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   den_q, den_d;
  logic                frame_q, frame_d;

  logic                boundary;
  logic                in_dead;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   sel;
  logic [6:0]          glyph;
  logic [7:0]          seg_raw;
  logic [DIGITS-1:0]   lz_blank;

  if (DEAD == 0) begin : g_nodead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt_q < CW'(DEAD));
  end

`ifdef SEG7_LZB_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero    = all_zero && (disp_val_q[4*k +: 4] == 4'h0);
      lz_blank[k] = all_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  seg7_glyph u_glyph (
    .nib_i (cur_nib),
    .seg_o (glyph)
  );

  always_comb begin
    boundary = (cnt_q == '0) && (idx_q == '0);

    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // A boundary copy takes the old staging; a coincident load refills it and keeps pending set.
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pending_d    = pending_q;
    if (boundary && pending_q) begin
      disp_val_d   = stg_val_q;
      disp_dp_d    = stg_dp_q;
      disp_blank_d = stg_blank_q;
      pending_d    = 1'b0;
    end
    stg_val_d   = stg_val_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    if (load) begin
      stg_val_d   = value;
      stg_dp_d    = dp;
      stg_blank_d = blank;
      pending_d   = 1'b1;
    end

    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel       = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_nib   = disp_val_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = disp_blank_q[k] | lz_blank[k];
        sel[k]    = 1'b1;
      end
    end

    seg_raw         = {1'b0, cur_blank ? 7'h00 : glyph};
    seg_raw[SEG_DP] = cur_dp;

    if (in_dead) begin
      seg_d = SEG_OFF;
      den_d = DIG_OFF;
    end else begin
      seg_d = seg_raw ^ SEG_OFF;
      den_d = sel ^ DIG_OFF;
    end
    frame_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      den_q        <= DIG_OFF;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      den_q        <= den_d;
      frame_q      <= frame_d;
    end
  end

  assign segments = seg_q;
  assign digit_en = den_q;
  assign frame    = frame_q;

endmodule
